// File: rtl/float_sub16_seq.sv
// Sequential half-precision subtractor (result = floatA - floatB), truncating, no denormals/NaN.
// Walks IDLE -> ALIGN -> ADD -> NORM -> DONE with valid/ready handshakes on both sides.
module float_sub16_seq #(
    parameter bit SAT_OVERFLOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds its data stable until then, and ready never waits on valid.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]       a_q;
    logic [15:0]       b_q;
    logic [10:0]       fa_q;
    logic [10:0]       fb_q;
    logic [10:0]       frac_q;
    // One bit wider than the 6-bit working exponent so a carry past 31 stays visible.
    logic signed [6:0] exp_q;
    logic              sign_q;
    logic              special_q;
    logic [15:0]       special_val_q;

    logic [4:0]        ea;
    logic [4:0]        eb;
    logic [4:0]        ediff;
    logic              a_ge_b;
    logic [10:0]       fra;
    logic [10:0]       frb;
    logic [10:0]       fa_al;
    logic [10:0]       fb_al;
    logic signed [6:0] exp_al;
    logic              a_zero;
    logic              b_zero;
    logic              is_special;
    logic [15:0]       special_val;

    logic              eff_sb;
    logic [11:0]       sum;
    logic [11:0]       diff;
    logic [10:0]       pos_frac;
    logic [10:0]       neg_frac;
    logic [10:0]       add_frac;
    logic signed [6:0] add_exp;
    logic              add_sign;

    logic              norm_done;

    function automatic logic [15:0] pack(input logic s, input logic signed [6:0] e,
                                         input logic [10:0] f);
        logic [15:0] r;
        if (e < 7'sd0)
            r = 16'h0000;
        else if (e > 7'sd31)
            r = SAT_OVERFLOW ? {s, 5'h1F, 10'h000} : 16'h0000;
        else if (f == 11'd0)
            r = 16'h0000;
        else
            r = {s, e[4:0], f[9:0]};
        return r;
    endfunction

    // Alignment and special-case detection from the latched operands.
    always_comb begin
        ea     = a_q[14:10];
        eb     = b_q[14:10];
        fra    = {1'b1, a_q[9:0]};
        frb    = {1'b1, b_q[9:0]};
        a_ge_b = (ea >= eb);
        ediff  = a_ge_b ? (ea - eb) : (eb - ea);
        fa_al  = fra;
        fb_al  = frb;
        if (a_ge_b)
            fb_al = (ediff >= 5'd11) ? 11'd0 : (frb >> ediff);
        else
            fa_al = (ediff >= 5'd11) ? 11'd0 : (fra >> ediff);
        exp_al = signed'({2'b00, (a_ge_b ? ea : eb)});

        a_zero      = (a_q[14:0] == 15'd0);
        b_zero      = (b_q[14:0] == 15'd0);
        is_special  = a_zero || b_zero || (a_q == b_q);
        special_val = 16'h0000;
        if (a_zero)
            special_val = {~b_q[15], b_q[14:0]};
        else if (b_zero)
            special_val = a_q;
    end

    // Signed-magnitude add of the aligned fractions.
    always_comb begin
        eff_sb   = ~b_q[15];
        sum      = {1'b0, fa_q} + {1'b0, fb_q};
        pos_frac = a_q[15] ? fb_q : fa_q;
        neg_frac = a_q[15] ? fa_q : fb_q;
        diff     = {1'b0, pos_frac} - {1'b0, neg_frac};
        add_frac = sum[10:0];
        add_exp  = exp_q;
        add_sign = a_q[15];
        if (a_q[15] == eff_sb) begin
            if (sum[11]) begin
                add_frac = sum[11:1];
                add_exp  = exp_q + 7'sd1;
            end
        end else begin
            if (diff[11]) begin
                add_frac = -diff[10:0];
                add_sign = 1'b1;
            end else begin
                add_frac = diff[10:0];
                add_sign = 1'b0;
            end
        end
    end

    assign norm_done = frac_q[10] || (frac_q == 11'd0);

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Special results spend the ADD slot idle so they land two edges after accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = special_q ? DONE : NORM;
            NORM:    if (norm_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && reset;
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q           <= 16'h0000;
            b_q           <= 16'h0000;
            fa_q          <= 11'd0;
            fb_q          <= 11'd0;
            frac_q        <= 11'd0;
            exp_q         <= 7'sd0;
            sign_q        <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= 16'h0000;
            result        <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= floatA;
                        b_q <= floatB;
                    end
                end
                ALIGN: begin
                    fa_q          <= fa_al;
                    fb_q          <= fb_al;
                    exp_q         <= exp_al;
                    special_q     <= is_special;
                    special_val_q <= special_val;
                end
                ADD: begin
                    if (special_q) begin
                        result <= special_val_q;
                    end else begin
                        frac_q <= add_frac;
                        exp_q  <= add_exp;
                        sign_q <= add_sign;
                    end
                end
                NORM: begin
                    if (norm_done) begin
                        result <= pack(sign_q, exp_q, frac_q);
                    end else begin
                        frac_q <= frac_q << 1;
                        exp_q  <= exp_q - 7'sd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_sub16_seq.sv
// Bench for float_sub16_seq: directed test-plan cases, a reset abort, then random operands
// checked against an integer-arithmetic reference model.
module tb_float_sub16_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] floatA = 16'h0000;
    logic [15:0] floatB = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        busy;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    float_sub16_seq dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .floatA(floatA),
        .floatB(floatB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: values as signed integers of fraction units, truncating alignment.
    function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output int lat);
        int ea, eb, e, ma, mb, va, vb, s, mag, k;
        logic sg;
        lat = 2;
        if (a[14:0] == 15'd0) begin
            r = {~b[15], b[14:0]};
            return;
        end
        if (b[14:0] == 15'd0) begin
            r = a;
            return;
        end
        if (a == b) begin
            r = 16'h0000;
            return;
        end
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = 1024 + int'(a[9:0]);
        mb = 1024 + int'(b[9:0]);
        e  = (ea > eb) ? ea : eb;
        ma = ((e - ea) >= 11) ? 0 : (ma >> (e - ea));
        mb = ((e - eb) >= 11) ? 0 : (mb >> (e - eb));
        va = a[15] ? -ma : ma;
        vb = b[15] ? mb : -mb;
        s  = va + vb;
        sg = (s < 0) || (s == 0 && a[15] && !b[15]);
        mag = (s < 0) ? -s : s;
        if (mag >= 2048) begin
            mag = mag / 2;
            e = e + 1;
        end
        k = 0;
        while (mag != 0 && mag < 1024) begin
            mag = mag * 2;
            e = e - 1;
            k++;
        end
        lat = 3 + k;
        if (e < 0 || mag == 0)
            r = 16'h0000;
        else if (e > 31)
            r = {sg, 5'h1F, 10'h000};
        else
            r = {sg, 5'(e), 10'(mag)};
    endfunction

    task automatic wait_in_ready();
        int cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e_r, input int e_lat, input int hold);
        int lat;
        string tag;
        tag = $sformatf("%h-%h", a, b);
        floatA = a;
        floatB = b;
        in_valid = 1'b1;
        wait_in_ready();
        @(posedge clk); #1;
        exp_q.push_back(e_r);
        check({"busy ", tag}, busy, 1);
        lat = 0;
        while (!out_valid && lat < 30) begin
            in_valid = 1'($urandom_range(0, 1));
            floatA = 16'($urandom);
            floatB = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({"latency ", tag}, lat, e_lat);
        repeat (hold) begin
            @(posedge clk); #1;
            check({"hold_valid ", tag}, out_valid, 1);
            check({"hold_in_ready ", tag}, in_ready, 0);
            check({"hold_result ", tag}, result, e_r);
        end
        out_ready = 1'b1;
        check({"result ", tag}, result, exp_q.pop_front());
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({"post_valid ", tag}, out_valid, 0);
        check({"post_in_ready ", tag}, in_ready, 1);
        check({"post_result ", tag}, result, e_r);
    endtask

    task automatic run_rand(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] e_r;
        int e_lat;
        ref_sub(a, b, e_r, e_lat);
        run_op(a, b, e_r, e_lat, $urandom_range(0, 3));
    endtask

    initial begin
        logic [15:0] a, b;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        run_op(16'h4200, 16'h3C00, 16'h4000, 3, 0);
        run_op(16'h3C00, 16'hBC00, 16'h4000, 3, 0);
        run_op(16'h3E00, 16'h3D00, 16'h3400, 5, 0);
        run_op(16'h4500, 16'h4500, 16'h0000, 2, 0);
        run_op(16'h0000, 16'h3C00, 16'hBC00, 2, 0);
        run_op(16'h4400, 16'h0000, 16'h4400, 2, 0);
        run_op(16'h0500, 16'h0480, 16'h0000, 6, 0);
        run_op(16'h7C00, 16'hFC00, 16'h7C00, 3, 0);
        run_op(16'h4200, 16'h3C00, 16'h4000, 3, 4);

        // Abort 1.5 - 1.25 while it is normalising.
        floatA = 16'h3E00;
        floatB = 16'h3D00;
        in_valid = 1'b1;
        wait_in_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy", busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 16'h0000);
        check("abort_busy_low", busy, 0);
        check("abort_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("abort_rel_in_ready", in_ready, 1);
        run_op(16'h4200, 16'h3C00, 16'h4000, 3, 0);

        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 5))
                1: b = {b[15], a[14:10], b[9:0]};
                2: b = a ^ 16'h8000;
                3: b = a;
                4: if ($urandom_range(0, 1) == 1) a[14:0] = 15'd0; else b[14:0] = 15'd0;
                5: b = {b[15], 5'(a[14:10] - 5'($urandom_range(1, 3))), b[9:0]};
                default: ;
            endcase
            run_rand(a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
